// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor computing Diff = A - B, LSB first, one bit
//   per clock. Each step is a full subtractor whose borrow is kept in a
//   flip-flop. A single-cycle Start in IDLE latches the operands. Done pulses
//   for one cycle when Diff/Borrow/Ovf are final.
//
//   Ports
//     Clk    : clock, rising edge
//     Rst    : synchronous active-high reset (priority over everything)
//     Start  : begin request, honoured only while Busy=0
//     A, B   : minuend / subtrahend, sampled on the accepted Start edge
//     Busy   : high in RUN and DONE
//     Done   : one-cycle pulse, result valid
//     Diff   : A - B modulo 2^WIDTH
//     Borrow : 1 when unsigned A < B
//     Ovf    : signed overflow (0 unless SERIAL_SUB_SIGNED_OVF_EN is defined)
//
//   Build option
//     SERIAL_SUB_SIGNED_OVF_EN : when defined, the operand MSBs are kept and
//     Ovf is registered on entry to DONE. When undefined, Ovf is tied to 0.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             Ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One full-subtractor step: returns {borrow_out, diff_bit}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
    logic d;
    logic bout;
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
    return {bout, d};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       step;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic am_q, am_d;
  logic bm_q, bm_d;
  logic ovf_q, ovf_d;
`endif

  assign step = full_sub(a_sh_q[0], b_sh_q[0], br_q);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    diff_d  = diff_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    am_d    = am_q;
    bm_d    = bm_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          a_sh_d  = A;
          b_sh_d  = B;
          br_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          am_d    = A[WIDTH-1];
          bm_d    = B[WIDTH-1];
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        diff_d = {step[0], diff_q[WIDTH-1:1]};
        br_d   = step[1];
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          // step[0] is the final sign bit of Diff.
          ovf_d   = (am_q != bm_q) && (step[0] != am_q);
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      am_q    <= am_d;
      bm_q    <= bm_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign Busy   = (state_q != S_IDLE);
  assign Done   = (state_q == S_DONE);
  assign Diff   = diff_q;
  assign Borrow = br_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign Ovf    = ovf_q;
`else
  assign Ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed-vector bench for serial_subtractor at WIDTH=8. Expected results
//   are hand-computed constants. Ovf expectations follow the
//   SERIAL_SUB_SIGNED_OVF_EN build option.
module tb_serial_subtractor;

  localparam int W = 8;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         Start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Busy, Done, Borrow, Ovf;
  logic [W-1:0] Diff;

  int n_vec  = 0;
  int n_miss = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Start  (Start),
    .A      (A),
    .B      (B),
    .Busy   (Busy),
    .Done   (Done),
    .Diff   (Diff),
    .Borrow (Borrow),
    .Ovf    (Ovf)
  );

  always #5 Clk = ~Clk;

  // Directed vectors: A, B, Diff, Borrow, signed-overflow (when enabled).
  logic [W-1:0] va [5] = '{8'h35, 8'h12, 8'h00, 8'h80, 8'h7F};
  logic [W-1:0] vb [5] = '{8'h12, 8'h35, 8'h01, 8'h01, 8'hFF};
  logic [W-1:0] vd [5] = '{8'h23, 8'hDD, 8'hFF, 8'h7F, 8'h80};
  logic         vbr[5] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
  logic         vov[5] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One Start pulse, then wait (bounded) for Done and check the result.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic ebr, input logic eov);
    int n;
    A = a; B = b; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk({tag, "_busy"}, {31'd0, Busy}, 32'd1);
    n = 0;
    while (!Done && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 32'd8);
    chk({tag, "_diff"}, {24'd0, Diff}, {24'd0, ed});
    chk({tag, "_brw"}, {31'd0, Borrow}, {31'd0, ebr});
    chk({tag, "_ovf"}, {31'd0, Ovf}, {31'd0, eov & OVF_ON});
    tick();
    chk({tag, "_idle"}, {30'd0, Busy, Done}, 32'd0);
  endtask

  initial begin
    int done_c, n_done, k, last_c;
    logic [W-1:0] got_d;

    // Reset state
    tick(); tick();
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_diff", {24'd0, Diff}, 32'd0);
    chk("rst_brw", {31'd0, Borrow}, 32'd0);
    chk("rst_ovf", {31'd0, Ovf}, 32'd0);
    Rst = 1'b0;
    tick();

    // Single operations over the directed table
    for (int i = 0; i < 5; i++) run_op($sformatf("op%0d", i), va[i], vb[i], vd[i], vbr[i], vov[i]);

    // Start while busy: second Start with a different B must be ignored
    A = 8'h35; B = 8'h12; Start = 1'b1;
    n_done = 0; done_c = -1; got_d = '0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) Start = 1'b0;
      if (c == 3) begin Start = 1'b1; B = 8'hFF; end
      if (c == 4) Start = 1'b0;
      chk($sformatf("bsy_c%0d", c), {31'd0, Busy}, {31'd0, (c <= 9)});
      if (Done) begin n_done++; done_c = c; got_d = Diff; end
    end
    chk("bsy_ndone", n_done, 32'd1);
    chk("bsy_donec", done_c, 32'd9);
    chk("bsy_diff", {24'd0, got_d}, 32'h23);

    // Reset in the middle of RUN aborts without a Done
    A = 8'h35; B = 8'h12; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick(); tick(); tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_diff", {24'd0, Diff}, 32'd0);
    chk("abort_brw", {31'd0, Borrow}, 32'd0);
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      if (Done) n_done++;
      tick();
    end
    chk("abort_nodone", n_done, 32'd0);
    run_op("post_rst", 8'h10, 8'h10, 8'h00, 1'b0, 1'b0);

    // Back-to-back with Start held high: Done every 10 cycles
    k = 0; last_c = 0;
    A = va[0]; B = vb[0]; Start = 1'b1;
    for (int c = 1; c <= 80 && k < 5; c++) begin
      tick();
      if (Done) begin
        chk($sformatf("b2b%0d_gap", k), c - last_c, (k == 0) ? 32'd9 : 32'd10);
        chk($sformatf("b2b%0d_diff", k), {24'd0, Diff}, {24'd0, vd[k]});
        chk($sformatf("b2b%0d_brw", k), {31'd0, Borrow}, {31'd0, vbr[k]});
        chk($sformatf("b2b%0d_ovf", k), {31'd0, Ovf}, {31'd0, vov[k] & OVF_ON});
        last_c = c;
        k++;
        if (k < 5) begin A = va[k]; B = vb[k]; end
        else Start = 1'b0;
      end
    end
    chk("b2b_count", k, 32'd5);
    Start = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
